// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between pipeline stages, port arbiter and memory
//
// Purpose: groups the fetch, data-stage and memory-side signals of mem_port_arbiter.
// Modports:
//   slave  - arbiter view: takes requests and memReadData, drives grants, valids,
//            read data, memory address/write strobe and stalls.
//   master - pipeline/memory view: the opposite directions.
// Signals:
//   fetchReq/fetchAddress -> fetchGrant/fetchValid/fetchData      instruction fetch
//   dataReq/dataWrite/dataAddress/dataWriteValue
//                         -> dataGrant/dataValid/dataReadValue    load/store
//   memAddress/memWriteData/memWriteEnable <- memReadData         memory instance
//   stallFetch/stallData                                          pipeline freeze
interface mem_port_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             fetchReq;
    logic [WIDTH-1:0] fetchAddress;
    logic             fetchGrant;
    logic             fetchValid;
    logic [WIDTH-1:0] fetchData;

    logic             dataReq;
    logic             dataWrite;
    logic [WIDTH-1:0] dataAddress;
    logic [WIDTH-1:0] dataWriteValue;
    logic             dataGrant;
    logic             dataValid;
    logic [WIDTH-1:0] dataReadValue;

    logic [WIDTH-1:0] memAddress;
    logic [WIDTH-1:0] memWriteData;
    logic             memWriteEnable;
    logic [WIDTH-1:0] memReadData;

    logic             stallFetch;
    logic             stallData;

    modport slave (
        input  fetchReq, fetchAddress,
        input  dataReq, dataWrite, dataAddress, dataWriteValue,
        input  memReadData,
        output fetchGrant, fetchValid, fetchData,
        output dataGrant, dataValid, dataReadValue,
        output memAddress, memWriteData, memWriteEnable,
        output stallFetch, stallData
    );

    modport master (
        output fetchReq, fetchAddress,
        output dataReq, dataWrite, dataAddress, dataWriteValue,
        output memReadData,
        input  fetchGrant, fetchValid, fetchData,
        input  dataGrant, dataValid, dataReadValue,
        input  memAddress, memWriteData, memWriteEnable,
        input  stallFetch, stallData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
//
// Purpose: serialises fetch reads and data loads/stores onto a single memory port,
// waits a fixed memory latency, returns read data with a one-cycle valid pulse and
// raises stalls while a requester waits.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave (requests, grants, valids, memory port, stalls)
// Parameters: WIDTH (data/address bits), MEMLATENCY (1..15), MAXSTREAK (1..15).
// Build option: MEM_ARB_ROUND_ROBIN_EN - strict alternation under contention instead of
// data priority with a starvation limit; MAXSTREAK and the streak counter go away.
module mem_port_arbiter #(
    parameter int WIDTH      = 8,
    parameter int MEMLATENCY = 1
`ifndef MEM_ARB_ROUND_ROBIN_EN
    ,
    parameter int MAXSTREAK  = 4
`endif
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(MEMLATENCY - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_first;
    logic             r_owner_data;
    logic             r_write;
    logic             r_we;
    logic             r_fetch_valid;
    logic             r_data_valid;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_fetch_data;
    logic [WIDTH-1:0] r_data_rd;

    logic w_arb_open;
    logic w_data_wins;
    logic w_data_grant;
    logic w_fetch_grant;
    logic w_accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_data;
    // Under contention the side that did not win last time goes next.
    assign w_data_wins = bus.dataReq & ~(bus.fetchReq & r_last_data);
`else
    localparam logic [3:0] LP_STREAK_MAX = 4'(MAXSTREAK);
    logic [3:0] r_streak;
    // Data has priority until it has starved a waiting fetch MAXSTREAK times.
    assign w_data_wins = bus.dataReq & ~(bus.fetchReq & (r_streak == LP_STREAK_MAX));
`endif

    assign w_arb_open    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_data_grant  = w_arb_open & w_data_wins;
    assign w_fetch_grant = w_arb_open & bus.fetchReq & ~w_data_wins;
    assign w_accept      = w_data_grant | w_fetch_grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_first       <= 1'b0;
            r_owner_data  <= 1'b0;
            r_write       <= 1'b0;
            r_we          <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_fetch_data  <= '0;
            r_data_rd     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_data   <= 1'b0;
`else
            r_streak      <= 4'd0;
`endif
        end else begin
            r_we          <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_data_valid  <= 1'b0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (w_accept) begin
                r_last_data <= w_data_grant;
            end
`else
            if (!bus.fetchReq || w_fetch_grant) begin
                r_streak <= 4'd0;
            end else if (w_data_grant && (r_streak != LP_STREAK_MAX)) begin
                r_streak <= r_streak + 4'd1;
            end
`endif

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_owner_data <= w_data_grant;
                        r_addr       <= w_data_grant ? bus.dataAddress : bus.fetchAddress;
                        r_write      <= w_data_grant & bus.dataWrite;
                        r_we         <= w_data_grant & bus.dataWrite;
                        if (w_data_grant) begin
                            r_wdata <= bus.dataWriteValue;
                        end
                        r_first      <= 1'b1;
                        r_cnt        <= LP_CNT_INIT;
                        r_state      <= ST_ACCESS;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // The first ACCESS cycle is the address-issue cycle; the memory's
                    // MEMLATENCY cycles are counted after it, so read data is sampled
                    // at grant edge + MEMLATENCY + 1.
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_write) begin
                            if (r_owner_data) begin
                                r_data_rd <= bus.memReadData;
                            end else begin
                                r_fetch_data <= bus.memReadData;
                            end
                        end
                        r_data_valid  <= r_owner_data;
                        r_fetch_valid <= ~r_owner_data;
                        r_state       <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fetchGrant     = w_fetch_grant;
    assign bus.dataGrant      = w_data_grant;
    assign bus.fetchValid     = r_fetch_valid;
    assign bus.dataValid      = r_data_valid;
    assign bus.fetchData      = r_fetch_data;
    assign bus.dataReadValue  = r_data_rd;
    assign bus.memAddress     = r_addr;
    assign bus.memWriteData   = r_wdata;
    assign bus.memWriteEnable = r_we;
    assign bus.stallFetch     = bus.fetchReq & ~w_fetch_grant;
    assign bus.stallData      = bus.dataReq & ~w_data_grant;

endmodule
